// File: rtl/avst_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : avst_pkt_fifo
// Purpose  : Avalon-ST packet FIFO with multi-symbol beats, empty and channel
//            sidebands. Store-and-forward (STORE_FWD=1) or cut-through
//            (STORE_FWD=0). Framing errors (orphan beats, SOP inside a
//            packet, oversize packets in store-and-forward) are dropped or
//            repaired and counted in err_cnt.
// Ports    : clk, srst (async, active-high)
//            snk_*  : AVST sink (readyLatency 0)
//            src_*  : AVST source, driven from an output register
//            used_words : entries in storage (committed + uncommitted)
//            err_cnt    : saturating framing-error counter
// Revision : 1.0 - initial release
// ============================================================================
module avst_pkt_fifo #(
  parameter int DWIDTH    = 8,
  parameter int SYMBOLS   = 1,
  parameter int EWIDTH    = (SYMBOLS > 1 ? $clog2(SYMBOLS) : 1),
  parameter int CHWIDTH   = 1,
  parameter int DEPTH     = 64,
  parameter int STORE_FWD = 1
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic [DWIDTH-1:0]        snk_data,
  input  logic                     snk_startofpacket,
  input  logic                     snk_endofpacket,
  input  logic [EWIDTH-1:0]        snk_empty,
  input  logic [CHWIDTH-1:0]       snk_channel,
  input  logic                     snk_valid,
  output logic                     snk_ready,
  output logic [DWIDTH-1:0]        src_data,
  output logic                     src_startofpacket,
  output logic                     src_endofpacket,
  output logic [EWIDTH-1:0]        src_empty,
  output logic [CHWIDTH-1:0]       src_channel,
  output logic                     src_valid,
  input  logic                     src_ready,
  output logic [$clog2(DEPTH):0]   used_words,
  output logic [15:0]              err_cnt
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = DWIDTH + 2 + EWIDTH + CHWIDTH;
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PKT     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t             r_state;
  logic [AW:0]        r_wr_ptr;
  logic [AW:0]        r_commit_ptr;
  logic [AW:0]        r_rd_ptr;
  logic [ENTRY_W-1:0] r_mem [DEPTH];

  logic               w_full;
  logic               w_accept;
  logic               w_oversize;
  logic               w_we;
  logic [AW:0]        w_wptr;
  logic [AW:0]        w_wr_nxt;
  logic [AW:0]        w_commit_nxt;
  state_t             w_state_nxt;
  logic               w_err_inc;
  logic               w_avail;
  logic               w_load;
  logic [ENTRY_W-1:0] w_rd_entry;

  // Pointers are one bit wider than the address so full and empty differ.
  assign w_full     = ((r_wr_ptr - r_rd_ptr) == C_DEPTH);
  assign snk_ready  = !srst && ((r_state == ST_DISCARD) || !w_full);
  assign w_accept   = snk_valid && snk_ready;
  assign used_words = r_wr_ptr - r_rd_ptr;

  // The buffer is full of a single uncommitted packet: it can never complete,
  // so it is thrown away and the rest of it is discarded on arrival.
  assign w_oversize = (STORE_FWD != 0) && (r_state == ST_PKT) && w_full &&
                      (r_rd_ptr == r_commit_ptr);

  always_comb begin
    w_we         = 1'b0;
    w_wptr       = r_wr_ptr;
    w_wr_nxt     = r_wr_ptr;
    w_commit_nxt = r_commit_ptr;
    w_state_nxt  = r_state;
    w_err_inc    = 1'b0;
    case (r_state)
      ST_PKT: begin
        if (w_oversize) begin
          w_wr_nxt    = r_commit_ptr;
          w_err_inc   = 1'b1;
          w_state_nxt = ST_DISCARD;
        end else if (w_accept) begin
          if (snk_startofpacket) begin
            // SOP inside a packet: in store-and-forward the partial packet
            // is dropped by writing the new SOP over it.
            w_err_inc = 1'b1;
            if (STORE_FWD != 0) w_wptr = r_commit_ptr;
          end
          w_we        = 1'b1;
          w_state_nxt = snk_endofpacket ? ST_IDLE : ST_PKT;
        end
      end
      default: begin
        // IDLE and DISCARD; after an oversize rewind the buffer is empty,
        // so a SOP in DISCARD starts a packet exactly as in IDLE.
        if (w_accept) begin
          if (snk_startofpacket) begin
            w_we        = 1'b1;
            w_state_nxt = snk_endofpacket ? ST_IDLE : ST_PKT;
          end else if (r_state == ST_IDLE) begin
            w_err_inc = 1'b1;
          end else if (snk_endofpacket) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
    endcase
    if (w_we) begin
      w_wr_nxt = w_wptr + C_ONE;
      if ((STORE_FWD == 0) || snk_endofpacket) w_commit_nxt = w_wptr + C_ONE;
    end
  end

  // Storage array: no reset needed, only committed entries are ever read.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wptr[AW-1:0]] <= {snk_data, snk_startofpacket, snk_endofpacket,
                                snk_empty, snk_channel};
    end
  end

  assign w_avail    = (r_rd_ptr != r_commit_ptr);
  assign w_load     = w_avail && (!src_valid || src_ready);
  assign w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      r_state           <= ST_IDLE;
      r_wr_ptr          <= '0;
      r_commit_ptr      <= '0;
      r_rd_ptr          <= '0;
      err_cnt           <= '0;
      src_valid         <= 1'b0;
      src_data          <= '0;
      src_startofpacket <= 1'b0;
      src_endofpacket   <= 1'b0;
      src_empty         <= '0;
      src_channel       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_ptr     <= w_wr_nxt;
      r_commit_ptr <= w_commit_nxt;
      if (w_err_inc && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
      if (w_load) begin
        r_rd_ptr  <= r_rd_ptr + C_ONE;
        src_valid <= 1'b1;
        {src_data, src_startofpacket, src_endofpacket,
         src_empty, src_channel} <= w_rd_entry;
      end else if (src_ready) begin
        src_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avst_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_avst_pkt_fifo
// Purpose  : Self-checking bench for avst_pkt_fifo. Two instances share one
//            stimulus bus selected by sel: u_sf (store-and-forward, DEPTH 8)
//            and u_ct (cut-through, DEPTH 8); both 32-bit, 4 symbols.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avst_pkt_fifo;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
    logic [1:0]  emp;
    logic [1:0]  ch;
  } beat_t;

  typedef struct {
    logic        v;
    beat_t       in;
    logic        e_v;
    beat_t       e_out;
    logic [3:0]  e_used;
    logic [15:0] e_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        sel = 1'b0;
  logic        d_valid = 1'b0, d_sop = 1'b0, d_eop = 1'b0;
  logic [31:0] d_data = '0;
  logic [1:0]  d_emp = '0, d_ch = '0;
  logic        fix_ready = 1'b1, rand_en = 1'b0, r_rand = 1'b0, mon_en = 1'b0;
  logic        src_ready;

  logic        a_rdy, a_sval, a_ssop, a_seop;
  logic [31:0] a_sdata;
  logic [1:0]  a_semp, a_sch;
  logic [3:0]  a_used;
  logic [15:0] a_err;
  logic        b_rdy, b_sval, b_ssop, b_seop;
  logic [31:0] b_sdata;
  logic [1:0]  b_semp, b_sch;
  logic [3:0]  b_used;
  logic [15:0] b_err;

  logic        m_rdy, m_sval, m_ssop, m_seop;
  logic [31:0] m_sdata;
  logic [1:0]  m_semp, m_sch;
  logic [3:0]  m_used;
  logic [15:0] m_err;

  int n_chk = 0, n_pass = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  assign src_ready = rand_en ? r_rand : fix_ready;
  assign m_rdy   = sel ? b_rdy   : a_rdy;
  assign m_sval  = sel ? b_sval  : a_sval;
  assign m_ssop  = sel ? b_ssop  : a_ssop;
  assign m_seop  = sel ? b_seop  : a_seop;
  assign m_sdata = sel ? b_sdata : a_sdata;
  assign m_semp  = sel ? b_semp  : a_semp;
  assign m_sch   = sel ? b_sch   : a_sch;
  assign m_used  = sel ? b_used  : a_used;
  assign m_err   = sel ? b_err   : a_err;

  avst_pkt_fifo #(.DWIDTH(32), .SYMBOLS(4), .CHWIDTH(2), .DEPTH(8), .STORE_FWD(1)) u_sf (
    .clk(clk), .srst(srst),
    .snk_data(d_data), .snk_startofpacket(d_sop), .snk_endofpacket(d_eop),
    .snk_empty(d_emp), .snk_channel(d_ch), .snk_valid(d_valid && !sel),
    .snk_ready(a_rdy),
    .src_data(a_sdata), .src_startofpacket(a_ssop), .src_endofpacket(a_seop),
    .src_empty(a_semp), .src_channel(a_sch), .src_valid(a_sval),
    .src_ready(src_ready), .used_words(a_used), .err_cnt(a_err));

  avst_pkt_fifo #(.DWIDTH(32), .SYMBOLS(4), .CHWIDTH(2), .DEPTH(8), .STORE_FWD(0)) u_ct (
    .clk(clk), .srst(srst),
    .snk_data(d_data), .snk_startofpacket(d_sop), .snk_endofpacket(d_eop),
    .snk_empty(d_emp), .snk_channel(d_ch), .snk_valid(d_valid && sel),
    .snk_ready(b_rdy),
    .src_data(b_sdata), .src_startofpacket(b_ssop), .src_endofpacket(b_seop),
    .src_empty(b_semp), .src_channel(b_sch), .src_valid(b_sval),
    .src_ready(src_ready), .used_words(b_used), .err_cnt(b_err));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic beat_t mkb(input logic sop, input logic eop, input logic [31:0] data,
                                input logic [1:0] emp, input logic [1:0] ch);
    beat_t b;
    b.sop = sop; b.eop = eop; b.data = data; b.emp = emp; b.ch = ch;
    return b;
  endfunction

  function automatic vec_t mkv(input logic v, input beat_t in, input logic e_v,
                               input beat_t e_out, input logic [3:0] e_used,
                               input logic [15:0] e_err);
    vec_t t;
    t.v = v; t.in = in; t.e_v = e_v; t.e_out = e_out; t.e_used = e_used; t.e_err = e_err;
    return t;
  endfunction

  // Presents one beat and holds it until the selected DUT takes it.
  task automatic send_beat(input beat_t b, output int stalls);
    int  n;
    logic rdy;
    stalls = 0;
    @(negedge clk);
    d_valid = 1'b1; d_sop = b.sop; d_eop = b.eop; d_data = b.data; d_emp = b.emp; d_ch = b.ch;
    for (n = 0; n < 64; n++) begin
      #1;
      rdy = m_rdy;
      @(posedge clk);
      if (rdy) break;
      stalls++;
      @(negedge clk);
    end
    if (n == 64) begin
      n_chk++;
      $display("FAIL accept_timeout: snk_ready never high (t=%0t)", $time);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    d_valid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [31:0] base, input logic [1:0] ch,
                          input logic [1:0] emp, input logic expect_out, output int stalls);
    beat_t b;
    int    s;
    stalls = 0;
    for (int k = 0; k < len; k++) begin
      b = mkb(k == 0, k == len - 1, base + 32'(k), (k == len - 1) ? emp : 2'd0, ch);
      if (expect_out) exp_q.push_back(b);
      send_beat(b, s);
      stalls += s;
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #3;
      if (exp_q.size() == 0 && !m_sval) break;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) r_rand <= 1'($urandom_range(0, 1));

  // Output monitor: scoreboard pops on each handshake, and a stalled beat
  // must be presented unchanged on the next cycle.
  beat_t m_prev;
  logic  m_prev_stall = 1'b0;
  always begin
    beat_t cur, e;
    @(negedge clk);
    #2;
    cur = {m_ssop, m_seop, m_sdata, m_semp, m_sch};
    if (mon_en) begin
      if (m_prev_stall) begin
        check("stall_valid", 64'(m_sval), 64'd1);
        check("stall_hold", 64'(cur), 64'(m_prev));
      end
      if (m_sval && src_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_beat: got %h expected none (t=%0t)", cur, $time);
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'(cur), 64'(e));
        end
      end
      m_prev_stall = m_sval && !src_ready;
      m_prev = cur;
    end else begin
      m_prev_stall = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tv[8];
    int   st;
    beat_t b;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_snk_ready", 64'(a_rdy), 64'd0);
    check("rst_src_valid", 64'(a_sval), 64'd0);
    check("rst_used", 64'(a_used), 64'd0);
    check("rst_err", 64'(a_err), 64'd0);
    check("rst_ct_src_valid", 64'(b_sval), 64'd0);
    srst = 1'b0;
    @(negedge clk);
    check("post_rst_ready_sf", 64'(a_rdy), 64'd1);
    check("post_rst_ready_ct", 64'(b_rdy), 64'd1);

    // ---------------- cut-through vector table ----------------
    tv[0] = mkv(1, mkb(1,0,32'hC0DE0000,2'd0,2'd3), 0, mkb(0,0,0,0,0), 4'd1, 16'd0);
    tv[1] = mkv(1, mkb(0,0,32'hC0DE0001,2'd0,2'd3), 1, mkb(1,0,32'hC0DE0000,2'd0,2'd3), 4'd1, 16'd0);
    tv[2] = mkv(1, mkb(0,0,32'hC0DE0002,2'd0,2'd3), 1, mkb(0,0,32'hC0DE0001,2'd0,2'd3), 4'd1, 16'd0);
    tv[3] = mkv(1, mkb(0,0,32'hC0DE0003,2'd0,2'd3), 1, mkb(0,0,32'hC0DE0002,2'd0,2'd3), 4'd1, 16'd0);
    tv[4] = mkv(1, mkb(0,1,32'hC0DE0004,2'd2,2'd3), 1, mkb(0,0,32'hC0DE0003,2'd0,2'd3), 4'd1, 16'd0);
    tv[5] = mkv(0, mkb(0,0,32'h0,2'd0,2'd0),        1, mkb(0,1,32'hC0DE0004,2'd2,2'd3), 4'd0, 16'd0);
    tv[6] = mkv(1, mkb(0,1,32'hDEAD0006,2'd1,2'd1), 0, mkb(0,0,0,0,0), 4'd0, 16'd1);
    tv[7] = mkv(0, mkb(0,0,32'h0,2'd0,2'd0),        0, mkb(0,0,0,0,0), 4'd0, 16'd1);

    sel = 1'b1; fix_ready = 1'b1;
    d_valid = tv[0].v; {d_sop, d_eop, d_data, d_emp, d_ch} = tv[0].in;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("ct_vec%0d_valid", i), 64'(m_sval), 64'(tv[i].e_v));
      if (tv[i].e_v)
        check($sformatf("ct_vec%0d_beat", i),
              64'({m_ssop, m_seop, m_sdata, m_semp, m_sch}), 64'(tv[i].e_out));
      check($sformatf("ct_vec%0d_used", i), 64'(m_used), 64'(tv[i].e_used));
      check($sformatf("ct_vec%0d_err", i), 64'(m_err), 64'(tv[i].e_err));
      if (i < 7) begin
        d_valid = tv[i+1].v; {d_sop, d_eop, d_data, d_emp, d_ch} = tv[i+1].in;
      end else begin
        d_valid = 1'b0;
      end
    end
    sel = 1'b0;

    // ---------------- store-and-forward latency ----------------
    mon_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      b = mkb(k == 0, k == 4, 32'h5F000000 + 32'(k), (k == 4) ? 2'd3 : 2'd0, 2'd2);
      exp_q.push_back(b);
      send_beat(b, st);
      #1;
      check("sf_early_valid", 64'(a_sval), 64'd0);
    end
    @(negedge clk);
    d_valid = 1'b0;
    @(posedge clk);
    #1;
    check("sf_sop_latency", 64'({a_sval, a_ssop}), 64'b11);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("sf_contiguous", 64'(a_sval), 64'd1);
    end
    drain(50);
    check("sf_used_end", 64'(a_used), 64'd0);
    check("sf_err_end", 64'(a_err), 64'd0);

    // ---------------- oversize packet ----------------
    send_pkt(12, 32'h0B000000, 2'd1, 2'd0, 1'b0, st);
    idle();
    check("oversize_stalls", 64'(st), 64'd1);
    check("oversize_err", 64'(a_err), 64'd1);
    check("oversize_used", 64'(a_used), 64'd0);
    send_pkt(3, 32'h0C000000, 2'd2, 2'd1, 1'b1, st);
    idle();
    drain(50);
    check("after_oversize_err", 64'(a_err), 64'd1);

    // ---------------- reset mid-packet ----------------
    fix_ready = 1'b0;
    send_pkt(2, 32'h0D000000, 2'd0, 2'd0, 1'b1, st);
    for (int k = 0; k < 5; k++) begin
      send_beat(mkb(k == 0, 1'b0, 32'h0E000000 + 32'(k), 2'd0, 2'd1), st);
    end
    idle();
    check("pre_rst_used", 64'(a_used), 64'd6);
    check("pre_rst_valid", 64'(a_sval), 64'd1);
    mon_en = 1'b0;
    #3;
    srst = 1'b1;
    #1;
    check("async_rst_valid", 64'(a_sval), 64'd0);
    check("async_rst_used", 64'(a_used), 64'd0);
    check("async_rst_ready", 64'(a_rdy), 64'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    srst = 1'b0;
    fix_ready = 1'b1;
    mon_en = 1'b1;
    send_pkt(3, 32'h0F000000, 2'd3, 2'd2, 1'b1, st);
    idle();
    drain(50);
    check("post_rst_err", 64'(a_err), 64'd0);

    // ---------------- orphan beat, then SOP inside a packet ----------------
    send_beat(mkb(1'b0, 1'b0, 32'h0BAD0000, 2'd0, 2'd0), st);
    idle();
    repeat (3) @(negedge clk);
    check("orphan_err", 64'(a_err), 64'd1);
    check("orphan_used", 64'(a_used), 64'd0);
    send_beat(mkb(1'b1, 1'b0, 32'h10000000, 2'd0, 2'd1), st);
    send_beat(mkb(1'b0, 1'b0, 32'h10000001, 2'd0, 2'd1), st);
    send_beat(mkb(1'b0, 1'b0, 32'h10000002, 2'd0, 2'd1), st);
    send_pkt(3, 32'h20000000, 2'd2, 2'd3, 1'b1, st);
    idle();
    drain(50);
    check("sop_in_pkt_err", 64'(a_err), 64'd2);

    // ---------------- random backpressure, 200 packets ----------------
    rand_en = 1'b1;
    for (int p = 0; p < 200; p++) begin
      int len;
      logic [1:0] ch;
      len = $urandom_range(1, 8);
      ch  = 2'($urandom_range(0, 3));
      for (int k = 0; k < len; k++) begin
        b = mkb(k == 0, k == len - 1, $urandom, 2'($urandom_range(0, 3)), ch);
        exp_q.push_back(b);
        send_beat(b, st);
      end
    end
    idle();
    drain(3000);
    rand_en = 1'b0;
    check("rand_err", 64'(a_err), 64'd2);
    check("rand_used", 64'(a_used), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
